// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and link constants for the RX and TX blocks
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int CLK_HZ     = 100_000_000;
  localparam int BAUD       = 9600;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake between the UART receiver (master) and its consumer (slave)
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS
);
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 data_ready;
  logic                 rd_ack;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data,
    output data_ready,
    output frame_err,
    output overrun,
    input  rd_ack
  );

  modport slave (
    input  data,
    input  data_ready,
    input  frame_err,
    input  overrun,
    output rd_ack
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic multi-stage single-bit synchronizer with a selectable reset value
module sync_2ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on a 16x oversampling tick, with ready/ack byte handoff,
// framing-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int DATA_BITS   = uart_pkg::DATA_BITS,
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_baud,
  input  logic      i_rx,
  output logic      o_busy,
  uart_rx_if.master rx_if
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_armed;
  logic                 w_tick;
  logic                 w_fall;
  logic                 r_baud_q;
  logic                 r_rx_prev;
  uart_state_e          r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ready;
  logic                 r_frame_err;
  logic                 r_overrun;

  sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  // Goes high when w_rx_s first carries the real line level, so the synchronizer's reset value never counts as "seen high"
  sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_arm (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (1'b1),
    .o_q   (w_armed)
  );

  assign w_tick = i_baud & ~r_baud_q;
  assign w_fall = r_rx_prev & ~w_rx_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baud_q  <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_baud_q  <= i_baud;
      r_rx_prev <= w_armed & w_rx_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (rx_if.rd_ack) begin
        r_ready   <= 1'b0;
        r_overrun <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          if (w_fall) r_state <= START;
        end
        START: if (w_tick) begin
          if (r_tick_cnt == HALF_LAST) begin
            r_tick_cnt <= '0;
            if (!w_rx_s) begin
              r_bit_cnt <= '0;
              r_state   <= DATA;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        DATA: if (w_tick) begin
          if (r_tick_cnt == FULL_LAST) begin
            r_tick_cnt <= '0;
            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) r_state <= STOP;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          if (r_tick_cnt == FULL_LAST) begin
            r_tick_cnt <= '0;
            r_state    <= IDLE;
            if (w_rx_s) begin
              // A store overrides a same-cycle ack: the newest byte is always kept
              r_data    <= r_shift;
              r_ready   <= 1'b1;
              r_overrun <= ~rx_if.rd_ack & (r_overrun | r_ready);
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_if.data       = r_data;
  assign rx_if.data_ready = r_ready;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.overrun    = r_overrun;
  assign o_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: directed frames plus randomized frames
// checked against a frame-level model of the consumer-visible outputs.
module tb_uart_rx;

  localparam int BAUD_HALF = 4;
  localparam int BIT_CLKS  = 16 * 2 * BAUD_HALF;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic baud = 1'b0;
  logic rx   = 1'b1;
  logic busy;

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_baud (baud),
    .i_rx   (rx),
    .o_busy (busy),
    .rx_if  (rx_if)
  );

  int passed = 0;
  int total  = 0;
  int cyc = 0, ready_cyc = 0, start_cyc = 0;
  int fe_count = 0, fe_run = 0, fe_max = 0;
  logic prev_ready = 1'b0, prev_fe = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (BAUD_HALF) @(posedge clk);
      #1 baud = ~baud;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rx_if.data_ready === 1'b1 && prev_ready !== 1'b1) begin
      got_q.push_back(rx_if.data);
      ready_cyc = cyc;
    end
    prev_ready = rx_if.data_ready;
    if (rx_if.frame_err === 1'b1) begin
      if (prev_fe !== 1'b1) fe_count++;
      fe_run++;
      if (fe_run > fe_max) fe_max = fe_run;
    end else begin
      fe_run = 0;
    end
    prev_fe = rx_if.frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_if.rd_ack = 1'b1;
    step(1);
    rx_if.rd_ack = 1'b0;
  endtask

  task automatic wait_ready(input int bound, output logic ok);
    int n = 0;
    while (rx_if.data_ready !== 1'b1 && n < bound) begin
      step(1);
      n++;
    end
    ok = (rx_if.data_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b0;
    step(5);
    total++; if (rx_if.data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_if.data); else passed++;
    total++; if (rx_if.data_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", rx_if.data_ready); else passed++;
    total++; if (rx_if.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", rx_if.frame_err); else passed++;
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", rx_if.overrun); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    rst = 1'b0;
    step(300);
    total++; if (busy !== 1'b0) $display("FAIL low_at_release_busy: got %b want 0", busy); else passed++;
    rx = 1'b1;
    step(300);
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_single();
    int base = got_q.size();
    int fe0  = fe_count;
    int lat;
    send_frame(8'h55, 1'b1);
    step(40);
    lat = ready_cyc - start_cyc;
    total++; if (got_q.size() != base + 1) $display("FAIL single_count: got %0d want %0d", got_q.size(), base + 1); else passed++;
    total++; if (rx_if.data !== 8'h55) $display("FAIL single_data: got %h want 55", rx_if.data); else passed++;
    total++; if (rx_if.data_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", rx_if.data_ready); else passed++;
    total++; if (lat < 1200 || lat > 1240) $display("FAIL single_latency: got %0d clk want 1200..1240", lat); else passed++;
    total++; if (fe_count != fe0) $display("FAIL single_frame_err: got %0d pulses want %0d", fe_count, fe0); else passed++;
    pulse_ack();
    total++; if (rx_if.data_ready !== 1'b0) $display("FAIL single_ack_ready: got %b want 0", rx_if.data_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    int base = got_q.size();
    int fe0  = fe_count;
    fork
      begin
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          logic ok;
          wait_ready(3000, ok);
          total++; if (ok !== 1'b1) $display("FAIL b2b_ready_timeout: frame %0d got %b want 1", k, ok); else passed++;
          pulse_ack();
        end
      end
    join
    step(40);
    total++; if (got_q.size() != base + 2) $display("FAIL b2b_count: got %0d want %0d", got_q.size(), base + 2); else passed++;
    total++; if (got_q[base] !== 8'hA3) $display("FAIL b2b_first: got %h want a3", got_q[base]); else passed++;
    total++; if (got_q[base+1] !== 8'h0F) $display("FAIL b2b_second: got %h want 0f", got_q[base+1]); else passed++;
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", rx_if.overrun); else passed++;
    total++; if (fe_count != fe0) $display("FAIL b2b_frame_err: got %0d want %0d", fe_count, fe0); else passed++;
  endtask

  task automatic test_glitch();
    int base = got_q.size();
    int bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (busy === 1'b1) bc++;
      if (i == 32) rx = 1'b1;
      step(1);
    end
    total++; if (bc < 50 || bc > 70) $display("FAIL glitch_busy_len: got %0d clk want 50..70", bc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else passed++;
    total++; if (rx_if.data_ready !== 1'b0) $display("FAIL glitch_ready: got %b want 0", rx_if.data_ready); else passed++;
    total++; if (got_q.size() != base) $display("FAIL glitch_count: got %0d want %0d", got_q.size(), base); else passed++;
    send_frame(8'h3C, 1'b1);
    step(40);
    total++; if (rx_if.data !== 8'h3C) $display("FAIL glitch_next_data: got %h want 3c", rx_if.data); else passed++;
    total++; if (rx_if.data_ready !== 1'b1) $display("FAIL glitch_next_ready: got %b want 1", rx_if.data_ready); else passed++;
    pulse_ack();
  endtask

  task automatic test_frame_err();
    int base = got_q.size();
    int fe0  = fe_count;
    fe_max = 0;
    send_frame(8'hFF, 1'b0);
    step(40);
    total++; if (fe_count != fe0 + 1) $display("FAIL ferr_pulses: got %0d want %0d", fe_count, fe0 + 1); else passed++;
    total++; if (fe_max != 1) $display("FAIL ferr_width: got %0d clk want 1", fe_max); else passed++;
    total++; if (rx_if.data_ready !== 1'b0) $display("FAIL ferr_ready: got %b want 0", rx_if.data_ready); else passed++;
    total++; if (rx_if.data !== 8'h3C) $display("FAIL ferr_data_kept: got %h want 3c", rx_if.data); else passed++;
    total++; if (got_q.size() != base) $display("FAIL ferr_count: got %0d want %0d", got_q.size(), base); else passed++;
    send_frame(8'h81, 1'b1);
    step(40);
    total++; if (rx_if.data !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", rx_if.data); else passed++;
    total++; if (rx_if.data_ready !== 1'b1) $display("FAIL ferr_next_ready: got %b want 1", rx_if.data_ready); else passed++;
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h12, 1'b1);
    step(20);
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL ovr_first: got %b want 0", rx_if.overrun); else passed++;
    send_frame(8'h34, 1'b1);
    step(40);
    total++; if (rx_if.data !== 8'h34) $display("FAIL ovr_data: got %h want 34", rx_if.data); else passed++;
    total++; if (rx_if.overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", rx_if.overrun); else passed++;
    total++; if (rx_if.data_ready !== 1'b1) $display("FAIL ovr_ready: got %b want 1", rx_if.data_ready); else passed++;
    pulse_ack();
    total++; if (rx_if.data_ready !== 1'b0) $display("FAIL ovr_ack_ready: got %b want 0", rx_if.data_ready); else passed++;
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL ovr_ack_clear: got %b want 0", rx_if.overrun); else passed++;
  endtask

  task automatic test_reset_mid();
    int base;
    send_frame(8'h77, 1'b1);
    step(40);
    total++; if (rx_if.data_ready !== 1'b1) $display("FAIL rmid_pre_ready: got %b want 1", rx_if.data_ready); else passed++;
    fork
      send_frame(8'hC6, 1'b1);
      begin
        step(7 * BIT_CLKS + BIT_CLKS / 2);
        rst = 1'b1;
        #1;
        total++; if (rx_if.data !== 8'h00) $display("FAIL rmid_data: got %h want 00", rx_if.data); else passed++;
        total++; if (rx_if.data_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", rx_if.data_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
        total++; if (rx_if.overrun !== 1'b0) $display("FAIL rmid_overrun: got %b want 0", rx_if.overrun); else passed++;
        step(3);
        rst = 1'b0;
      end
    join
    base = got_q.size();
    step(500);
    total++; if (rx_if.data_ready !== 1'b0) $display("FAIL rmid_tail_ready: got %b want 0", rx_if.data_ready); else passed++;
    total++; if (got_q.size() != base) $display("FAIL rmid_tail_count: got %0d want %0d", got_q.size(), base); else passed++;
    send_frame(8'h5A, 1'b1);
    step(40);
    total++; if (rx_if.data !== 8'h5A) $display("FAIL rmid_next_data: got %h want 5a", rx_if.data); else passed++;
    total++; if (rx_if.data_ready !== 1'b1) $display("FAIL rmid_next_ready: got %b want 1", rx_if.data_ready); else passed++;
    pulse_ack();
  endtask

  task automatic test_random();
    logic [7:0] m_data = 8'h5A;
    logic m_ready = 1'b0;
    logic m_ovr   = 1'b0;
    int   m_fe    = fe_count;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b    = 8'($urandom);
      logic       stop = ($urandom_range(0, 4) != 0);
      step($urandom_range(0, 200));
      send_frame(b, stop);
      step(40);
      if (stop) begin
        if (m_ready) m_ovr = 1'b1;
        m_data  = b;
        m_ready = 1'b1;
      end else begin
        m_fe++;
      end
      total++; if (rx_if.data !== m_data) $display("FAIL rand_data[%0d]: got %h want %h", k, rx_if.data, m_data); else passed++;
      total++; if (rx_if.data_ready !== m_ready) $display("FAIL rand_ready[%0d]: got %b want %b", k, rx_if.data_ready, m_ready); else passed++;
      total++; if (rx_if.overrun !== m_ovr) $display("FAIL rand_overrun[%0d]: got %b want %b", k, rx_if.overrun, m_ovr); else passed++;
      total++; if (fe_count != m_fe) $display("FAIL rand_frame_err[%0d]: got %0d want %0d", k, fe_count, m_fe); else passed++;
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        total++; if (rx_if.data_ready !== 1'b0 || rx_if.overrun !== 1'b0)
          $display("FAIL rand_ack[%0d]: got ready=%b overrun=%b want 0/0", k, rx_if.data_ready, rx_if.overrun);
        else passed++;
      end
    end
  endtask

  initial begin
    rx_if.rd_ack = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Recovers bytes from the serial input line using a 16x oversampling tick taken from the baud rate generator's `baud` square wave (about 153.6 kHz for 9600 baud at 100 MHz).
- Sits between the board RX pin and the consumer logic: display, command parser or the TX loopback.
- Hands each received byte to the consumer through a ready/ack handshake, and flags framing errors and overruns.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first.
- OVERSAMPLE, 16: tick periods per bit. Must be even and at least 4.
- SYNC_STAGES, 2: flip-flop stages in the rx input synchronizer.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous reset, active-high.
- baud  in  1  16x square wave from the baud rate generator. Same clock domain, registered at the source.
- rx  in  1  serial input, asynchronous, idle high.
- rd_ack  in  1  one-clk pulse from the consumer: byte taken.
- data  out  DATA_BITS  last received byte, held until the next byte is stored.
- data_ready  out  1  high while `data` holds an unread byte.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- overrun  out  1  sticky; set when a byte is stored while data_ready=1; cleared by rd_ack.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; data=0, data_ready=0, frame_err=0, overrun=0, busy=0.
  - tick counter=0, bit counter=0, synchronizer flops=1, baud edge register=0.
  - Reset mid-frame discards the partial byte with no error output. Reception resumes only after rx is seen high again in IDLE.
- Tick generation:
  - tick = baud & ~baud_q, where baud_q is baud registered once.
  - tick is one clk wide, once per baud period.
  - All bit timing counts ticks only. No other clk-rate timing.
- rx path: rx passes through SYNC_STAGES flops to give rx_s. Only rx_s is used internally.
- State IDLE:
  - tick count is held at 0.
  - A falling edge of rx_s (previous sample 1, current 0) moves to START and clears the tick count.
  - rx_s low at reset release is not a start edge.
- State START, on each tick the count increments:
  - At count = OVERSAMPLE/2-1 (7), sample rx_s.
  - If rx_s=0: clear the count, clear the bit counter, go to DATA.
  - If rx_s=1: false start, go to IDLE with no outputs.
- State DATA, on each tick the count increments:
  - At count = OVERSAMPLE-1 (15), sample rx_s into the shift register MSB and shift right. This samples mid-bit, LSB first.
  - On the same tick, clear the count and increment the bit counter.
  - After DATA_BITS samples, go to STOP.
- State STOP: at count = OVERSAMPLE-1, sample rx_s, then:
  - If rx_s=1: on the next clk, data takes the shift register and data_ready=1. If data_ready was already 1 and no rd_ack arrives in that same clk, overrun=1.
  - If rx_s=0: frame_err pulses for 1 clk. data and data_ready are unchanged.
  - Either way, go to IDLE.
  - A new falling edge is accepted from the clk after IDLE is entered, so back-to-back frames are received.
- Latency: data_ready rises 1 clk after the tick that samples mid-stop. This is about 9.5 bit times after the start edge, plus SYNC_STAGES+1 clk.
- Handshake:
  - rd_ack clears data_ready and overrun on the next clk.
  - rd_ack in the same clk as a store: the store wins. data_ready stays 1, overrun is not set, data takes the new byte.
  - rd_ack while data_ready=0 is ignored.
- Error rules: the overwrite on overrun is intentional, so the newest byte is kept. frame_err does not touch overrun.
- Widths:
  - tick counter is $clog2(OVERSAMPLE) bits.
  - bit counter is $clog2(DATA_BITS+1) bits.
  - Counters wrap only by explicit clear, never by natural overflow.

Decomposition:
- Shared package uart_pkg, also used by the TX block:
  - state enum IDLE/START/DATA/STOP;
  - constants OVERSAMPLE=16, DATA_BITS=8;
  - CLK_HZ=100_000_000 and BAUD=9600.
- One natural sub-module: sync_2ff, a generic SYNC_STAGES-deep bit synchronizer with a reset value parameter. Reused later for button and switch inputs.
- The tick edge detector stays inline.

Test Plan:
- Frame 0x55 (start, bits 1,0,1,0,1,0,1,0, stop=1) at 9600 baud: data=0x55, data_ready=1 about 9.5 bit times after the edge, frame_err=0. Then pulse rd_ack: data_ready=0 on the next clk.
- Two back-to-back frames 0xA3, 0x0F with zero idle gap, rd_ack after each: both received in order, no errors.
- rx low glitch of 4 ticks, then high: no state beyond START, busy returns low, data_ready stays 0. A following valid frame 0x3C is received correctly.
- Frame 0xFF with stop bit driven 0: frame_err is a single 1-clk pulse, data_ready stays 0, data keeps its previous value. The next frame 0x81 is received.
- Frames 0x12 then 0x34 with no rd_ack: data=0x34 and overrun=1. A single rd_ack clears data_ready and overrun.
- rst asserted mid-DATA of frame 0xC6: all outputs go to 0 immediately. The remainder of the frame causes no data_ready, and the next full frame 0x5A is received.
